// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Digit-serial adder/subtractor. Operands are accepted on a valid/ready
//   handshake, then added DIGIT bits per clock (least-significant digit
//   first) through a single registered carry. The result is presented on a
//   valid/ready output handshake.
//
// Parameters
//   WIDTH  operand and sum width (>= 1)
//   DIGIT  bits processed per clock; must divide WIDTH. N = WIDTH/DIGIT.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE)
//   a, b       operands
//   cin        carry-in (ignored when sub=1)
//   sub        0: a+b+cin, 1: a-b (a + ~b + 1)
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts the result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (1 = no borrow for subtraction)
//   ovf        two's-complement signed overflow
//   busy       high in RUN and DONE
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT-1:0]       a_dig, b_dig, s_dig;
    logic [DIGIT:0]         dsum;
    logic                   c_next, c_msb;
    logic [WIDTH+DIGIT-1:0] shift_cat;
    logic [WIDTH-1:0]       a_shift, b_shift;
    logic                   last;

    // One digit of ripple addition on the low end of the shift registers.
    assign a_dig  = a_q[DIGIT-1:0];
    assign b_dig  = b_q[DIGIT-1:0];
    assign dsum   = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    assign s_dig  = dsum[DIGIT-1:0];
    assign c_next = dsum[DIGIT];
    // Carry into the top bit of this digit, recovered from the sum bit.
    assign c_msb  = s_dig[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];

    // The A register doubles as the result accumulator: as operand digits
    // shift out of the bottom, result digits enter at the top. After N
    // shifts it holds the complete sum.
    assign shift_cat = {s_dig, a_q};
    assign a_shift   = shift_cat[WIDTH+DIGIT-1:DIGIT];
    assign b_shift   = b_q >> DIGIT;
    assign last      = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_shift;
                b_d     = b_shift;
                carry_d = c_next;
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    sum_d   = a_shift;
                    cout_d  = c_next;
                    ovf_d   = c_msb ^ c_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
